// File: rtl/narnet_sample_feeder.sv
// Sample feeder for a NARNET-style predictor: buffers raw samples, rescales them,
// hands them to the network and optionally iterates its predictions (closed loop).
module narnet_sample_feeder #(
  parameter int N       = 8,
  parameter int Q       = 7,
  parameter int DEPTH   = 8,
  parameter int OFFSET  = 0,
  parameter int GAIN    = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  input  logic         mode,
  input  logic [7:0]   horizon,
  output logic [N-1:0] x_in,
  output logic         x_ready,
  input  logic [N-1:0] y_out,
  input  logic         out_ready,
  output logic [N-1:0] pred_out,
  output logic         pred_valid,
  output logic         busy,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = 2 * N + 3;
  localparam logic signed [N:0]    OFF_X  = (N+1)'(OFFSET);
  localparam logic signed [N+1:0]  GAIN_X = (N+2)'(GAIN);
  localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (N - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-(1 << (N - 1)));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_NET, EMIT} state_t;
  state_t state, state_nxt;

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [7:0]    steps_left;
  logic [WW-1:0] wdog;
  logic          wdog_expired;

  logic signed [N:0]    diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic [N-1:0]         scaled;

  assign s_ready      = (count != CW'(DEPTH));
  assign push         = s_valid && s_ready;
  assign pop          = enable && (state == IDLE) && (count != '0);
  assign busy         = (state != IDLE);
  assign wdog_expired = (wdog == WW'(TIMEOUT));

  // Offset removal and gain are done at full precision on the FIFO head, then saturated.
  always_comb begin
    diff    = $signed({mem[rd_ptr][N-1], mem[rd_ptr]}) - OFF_X;
    prod    = $signed({{(N+2){diff[N]}}, diff}) * $signed({{(N+1){GAIN_X[N+1]}}, GAIN_X});
    shifted = prod >>> Q;
    if (shifted > SAT_HI)
      scaled = SAT_HI[N-1:0];
    else if (shifted < SAT_LO)
      scaled = SAT_LO[N-1:0];
    else
      scaled = shifted[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      x_in       <= '0;
      pred_out   <= '0;
      err        <= 1'b0;
      steps_left <= '0;
      wdog       <= '0;
    end else begin
      state <= state_nxt;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        x_in       <= scaled;
        steps_left <= mode ? horizon : '0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Watchdog and datapath only advance together with the FSM.
      if (enable) begin
        case (state)
          ISSUE: wdog <= '0;
          WAIT_NET: begin
            if (out_ready)
              pred_out <= y_out;
            else if (wdog_expired)
              err <= 1'b1;
            else
              wdog <= wdog + 1'b1;
          end
          EMIT: begin
            if (steps_left != '0) begin
              x_in       <= pred_out;
              steps_left <= steps_left - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    x_ready    = 1'b0;
    pred_valid = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (count != '0)
            state_nxt = ISSUE;
        end
        ISSUE: begin
          x_ready   = 1'b1;
          state_nxt = WAIT_NET;
        end
        WAIT_NET: begin
          if (out_ready)
            state_nxt = EMIT;
          else if (wdog_expired)
            state_nxt = IDLE;
        end
        EMIT: begin
          pred_valid = 1'b1;
          state_nxt  = (steps_left != '0) ? ISSUE : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_narnet_sample_feeder.sv
// Randomized scoreboard bench for narnet_sample_feeder with a transaction-level model
// of the scaling rule and the open/closed-loop issue order.
module tb_narnet_sample_feeder;

  localparam int N       = 8;
  localparam int Q       = 7;
  localparam int DEPTH   = 8;
  localparam int OFFSET  = -5;
  localparam int GAIN    = 450;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         s_valid = 1'b0;
  logic [N-1:0] s_data = '0;
  logic         mode = 1'b0;
  logic [7:0]   horizon = '0;
  logic [N-1:0] y_out = '0;
  logic         out_ready = 1'b0;
  logic         s_ready, x_ready, pred_valid, busy, err;
  logic [N-1:0] x_in, pred_out;

  int checks = 0;
  int passes = 0;
  logic [N-1:0] exp_base_q[$];
  logic [N-1:0] exp_pred_q[$];
  logic [N-1:0] next_fb;
  logic [N-1:0] mon_exp;
  logic [N-1:0] dir_samples [6] = '{8'h40, 8'h70, 8'h80, 8'h7F, 8'hFB, 8'h01};
  bit fb_pending = 0;
  bit resp_on = 0;
  int phase_steps = 0;
  int steps_rem = 0;
  int xr_count = 0;
  int pv_count = 0;
  int xr_mark, pv_mark;

  always #5 clk = ~clk;

  narnet_sample_feeder #(
    .N(N), .Q(Q), .DEPTH(DEPTH), .OFFSET(OFFSET), .GAIN(GAIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mode(mode), .horizon(horizon), .x_in(x_in), .x_ready(x_ready),
    .y_out(y_out), .out_ready(out_ready), .pred_out(pred_out), .pred_valid(pred_valid),
    .busy(busy), .err(err)
  );

  // Reference scaling: (raw - OFFSET) * GAIN / 2^Q rounded toward -inf, clamped to N bits.
  function automatic logic [N-1:0] model_scale(input logic [N-1:0] raw);
    int d, q;
    d = int'($signed(raw)) - OFFSET;
    q = (d * GAIN) >>> Q;
    if (q > (1 << (N - 1)) - 1) q = (1 << (N - 1)) - 1;
    if (q < -(1 << (N - 1))) q = -(1 << (N - 1));
    return N'(q);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: records accepted pushes and pops expectations whenever a strobe appears.
  always @(negedge clk) begin
    if (rst) begin
      if (x_ready || pred_valid) begin
        check_output("strobe_overlap", 32'(x_ready && pred_valid), 32'd0);
        check_output("strobe_when_disabled", 32'(enable), 32'd1);
      end
      if (x_ready) begin
        xr_count++;
        if (fb_pending) begin
          check_output("x_in_feedback", 32'(x_in), 32'(next_fb));
          fb_pending = 0;
        end else if (exp_base_q.size() == 0) begin
          check_output("x_ready_unexpected", 32'(x_ready), 32'd0);
        end else begin
          mon_exp = exp_base_q.pop_front();
          check_output("x_in_scaled", 32'(x_in), 32'(mon_exp));
          steps_rem = phase_steps;
        end
      end
      if (pred_valid) begin
        pv_count++;
        if (exp_pred_q.size() == 0) begin
          check_output("pred_valid_unexpected", 32'(pred_valid), 32'd0);
        end else begin
          mon_exp = exp_pred_q.pop_front();
          check_output("pred_out", 32'(pred_out), 32'(mon_exp));
          if (steps_rem > 0) begin
            fb_pending = 1;
            next_fb = mon_exp;
            steps_rem--;
          end
        end
      end
      if (s_valid && s_ready)
        exp_base_q.push_back(model_scale(s_data));
    end
  end

  // Network responder: answers each x_ready after a short random delay, holds until accepted.
  initial begin : responder
    bit got;
    forever begin
      @(negedge clk);
      if (x_ready && resp_on) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        y_out = N'($urandom);
        out_ready = 1'b1;
        exp_pred_q.push_back(y_out);
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
          @(negedge clk);
          if (pred_valid) got = 1;
        end
        if (!got) check_output("pred_valid_timeout", 32'(pred_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    end
  end

  task automatic apply_stimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      enable  = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 1) == 1);
      s_data  = (i < 6) ? dir_samples[i] : N'($urandom);
    end
  endtask

  task automatic push_one(input logic [N-1:0] d);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    @(posedge clk); #1;
    s_valid = 1'b0;
    enable  = 1'b1;
    done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (exp_base_q.size() == 0 && !busy) done = 1;
    end
    check_output("drain_busy", 32'(busy), 32'd0);
    check_output("drain_samples_left", 32'(exp_base_q.size()), 32'd0);
    check_output("drain_preds_left", 32'(exp_pred_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_x_in"}, 32'(x_in), 32'd0);
    check_output({tag, "_x_ready"}, 32'(x_ready), 32'd0);
    check_output({tag, "_pred_out"}, 32'(pred_out), 32'd0);
    check_output({tag, "_pred_valid"}, 32'(pred_valid), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_err"}, 32'(err), 32'd0);
    check_output({tag, "_s_ready"}, 32'(s_ready), 32'd1);
  endtask

  initial begin : guard
    #1ms;
    $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] aborted");
  end

  initial begin : stimulus
    bit seen;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Open loop with random enable gaps and random pushes.
    resp_on = 1; mode = 1'b0; horizon = 8'd5; phase_steps = 0;
    apply_stimulus(80);
    drain();

    // Closed loop, horizon 2: one sample yields three issues and three predictions.
    mode = 1'b1; horizon = 8'd2; phase_steps = 2;
    xr_mark = xr_count; pv_mark = pv_count;
    push_one(8'h33);
    drain();
    check_output("closed_loop_issues", 32'(xr_count - xr_mark), 32'd3);
    check_output("closed_loop_preds", 32'(pv_count - pv_mark), 32'd3);
    apply_stimulus(80);
    drain();

    // FIFO fill while stalled: exactly DEPTH accepts, then drained in order.
    mode = 1'b0; phase_steps = 0;
    xr_mark = xr_count;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(posedge clk); #1;
      enable = 1'b0; s_valid = 1'b1; s_data = N'($urandom);
      @(negedge clk);
      check_output("s_ready_fill", 32'(s_ready), 32'(i < DEPTH));
    end
    check_output("no_issue_while_disabled", 32'(xr_count - xr_mark), 32'd0);
    drain();
    check_output("fill_issue_count", 32'(xr_count - xr_mark), 32'(DEPTH));

    // Timeout: nobody answers, err rises after the watchdog expires.
    resp_on = 0;
    push_one(N'($urandom));
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (x_ready) seen = 1;
    end
    check_output("timeout_issue_seen", 32'(seen), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    check_output("timeout_err_early", 32'(err), 32'd0);
    check_output("timeout_busy_waiting", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    check_output("timeout_err_set", 32'(err), 32'd1);
    check_output("timeout_back_idle", 32'(busy), 32'd0);
    resp_on = 1;
    xr_mark = xr_count; pv_mark = pv_count;
    push_one(8'h10);
    drain();
    check_output("after_timeout_issue", 32'(xr_count - xr_mark), 32'd1);
    check_output("after_timeout_pred", 32'(pv_count - pv_mark), 32'd1);
    check_output("err_sticky", 32'(err), 32'd1);

    // Reset during WAIT_NET with three samples still queued.
    resp_on = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_valid = 1'b1; s_data = N'($urandom);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_output("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_base_q.delete(); exp_pred_q.delete(); fb_pending = 0;
    @(negedge clk);
    check_reset_values("midrun_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    xr_mark = xr_count; pv_mark = pv_count;
    out_ready = 1'b1; y_out = 8'h5A;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (20) @(negedge clk);
    check_output("post_reset_no_issue", 32'(xr_count - xr_mark), 32'd0);
    check_output("post_reset_no_pred", 32'(pv_count - pv_mark), 32'd0);
    check_output("post_reset_pred_out", 32'(pred_out), 32'd0);
    resp_on = 1;
    push_one(8'h7F);
    drain();
    check_output("post_reset_new_issue", 32'(xr_count - xr_mark), 32'd1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/narnet_sample_feeder.md
NARNET_SAMPLE_FEEDER -- requirements
Module: narnet_sample_feeder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N, 8, sample/data width.
- Q, 7, fractional bits.
- DEPTH, 8, input FIFO depth (power of 2, at least 2).
- OFFSET, 0, signed N-bit value subtracted from each raw sample.
- GAIN, 128, signed (N+2)-bit scale factor; GAIN = 2^Q means 1.0.
- TIMEOUT, 1023, maximum cycles to wait for out_ready.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  FSM/watchdog advance enable.
- s_valid  in  1  raw sample valid.
- s_data  in  N  raw signed sample.
- s_ready  out  1  FIFO can accept.
- mode  in  1  0 = open loop; 1 = closed loop (multi-step).
- horizon  in  8  extra closed-loop steps per popped sample.
- x_in  out  N  scaled sample to the network.
- x_ready  out  1  one-cycle start pulse to the network.
- y_out  in  N  network prediction.
- out_ready  in  1  network result valid.
- pred_out  out  N  captured prediction.
- pred_valid  out  1  one-cycle prediction strobe.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-003 FIFO: push on s_valid && s_ready. s_ready = (count != DEPTH), combinational from registered count.
REQ-004 FIFO pop happens only in IDLE with enable=1 and count>0; push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
REQ-005 Push is accepted regardless of enable; when full, s_ready=0 and s_data is ignored.
REQ-006 Scaling (registered on pop): p = (s_data - OFFSET) * GAIN, computed in 2N+3 bits, then arithmetic shift right by Q, then saturate to [-2^(N-1), 2^(N-1)-1], then load into x_in.
REQ-007 FSM states: IDLE, ISSUE, WAIT_NET, EMIT. The FSM holds state whenever enable=0; the watchdog also holds.
REQ-008 IDLE -> ISSUE on pop. At pop, sample mode and horizon into steps_left = (mode ? horizon : 0).
REQ-009 ISSUE: x_ready=1 for exactly one cycle; x_in stays stable from the ISSUE cycle until the next pop or feedback load; clear the watchdog; go to WAIT_NET.
REQ-010 WAIT_NET: an out_ready=1 seen in the ISSUE cycle is ignored.
- On out_ready=1: pred_out <= y_out, go to EMIT.
- On watchdog == TIMEOUT: err <= 1, go to IDLE with no pred_valid.
REQ-011 EMIT: pred_valid=1 for one cycle.
- If steps_left > 0: x_in <= pred_out (no rescaling), steps_left decrements, go to ISSUE.
- Otherwise go to IDLE.
REQ-012 Issue latency: pop cycle = T, x_ready high at T+1. The next pop is no earlier than the cycle after EMIT.
REQ-013 x_ready and pred_valid are never high in the same cycle, and never high while enable=0.
REQ-014 busy = (state != IDLE).
REQ-015 err clears only on reset.
REQ-016 mode/horizon changes while busy take effect only at the next pop.

Reset
REQ-017 rst=0 asynchronously forces the FSM to IDLE, clears FIFO count and pointers, and sets outputs to: x_in=0, x_ready=0, pred_out=0, pred_valid=0, busy=0, err=0. s_ready=1.
REQ-018 Reset mid-operation discards buffered samples and in-flight results; a later out_ready while in IDLE is ignored.

Verification
REQ-019 Open loop, GAIN=64, OFFSET=0: push 0x40 -> x_ready pulse with x_in=0x20; out_ready with y_out=0x11 -> pred_out=0x11, one pred_valid pulse, busy returns to 0.
REQ-020 Saturation, OFFSET=-64, GAIN=128: s_data=0x70 -> x_in=0x7F; s_data=0x80 -> x_in=0xC0 (no saturation).
REQ-021 Closed loop, mode=1, horizon=2: push one sample, responder returns 0x10, 0x20, 0x30 -> 3 x_ready pulses; 2nd and 3rd carry x_in=0x10 and 0x20; 3 pred_valid pulses; FIFO pops once.
REQ-022 FIFO full: push DEPTH+2 samples with the network stalled (enable=0) -> s_ready low after DEPTH accepts; samples issue later in order with no loss or duplication.
REQ-023 Timeout, TIMEOUT=15: no out_ready -> err=1 16 cycles after x_ready, FSM back in IDLE, next sample issues normally.
REQ-024 Reset asserted during WAIT_NET with 3 samples queued -> all outputs at reset values, count=0, no x_ready after release until a new push.
